// File: rtl/lcd_pkg.sv
// Shared LCD timing defaults, cell codes for the colour mapper, and pipeline flag record.
package lcd_pkg;

    localparam int unsigned DEF_H_ACTIVE = 480;
    localparam int unsigned DEF_H_FP     = 2;
    localparam int unsigned DEF_H_SYNC   = 41;
    localparam int unsigned DEF_H_BP     = 2;
    localparam int unsigned DEF_V_ACTIVE = 272;
    localparam int unsigned DEF_V_FP     = 2;
    localparam int unsigned DEF_V_SYNC   = 10;
    localparam int unsigned DEF_V_BP     = 2;

    localparam logic [2:0] CODE_CELL  = 3'b000;
    localparam logic [2:0] CODE_GRID  = 3'b001;
    localparam logic [2:0] CODE_ANT   = 3'b100;
    localparam logic [2:0] CODE_BLACK = 3'b111;

    typedef struct packed {
        logic active;
        logic grid;
        logic ant;
        logic hsync;
        logic vsync;
        logic frame_start;
    } pix_flags_t;

    // Syncs idle high so the first post-reset edge cannot emit a spurious sync pulse.
    localparam pix_flags_t FLAGS_IDLE = '{active: 1'b0, grid: 1'b0, ant: 1'b0,
                                          hsync: 1'b1, vsync: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/lcd_timing.sv
// Horizontal/vertical raster counters with combinational sync and active-area decode.
module lcd_timing
    import lcd_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync
);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hsync  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    end

endmodule

// File: rtl/cell_scanner.sv
// Raster scan source: reads the cell RAM per pixel and emits a 3-bit cell code
// with LCD syncs, all aligned two clocks after the raster counters.
module cell_scanner
    import lcd_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned CELL_LOG2 = 3,
    parameter int unsigned GRID_W    = 60,
    parameter int unsigned GRID_H    = 34,
    parameter int unsigned ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        ant_x,
    input  logic [5:0]        ant_y,
    output logic [ADDR_W-1:0] cell_rd_addr,
    input  logic              cell_rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic              enable,
    output logic [2:0]        icolor8,
    output logic              frame_start
);

    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0]           h_cnt;
    logic [VW-1:0]           v_cnt;
    logic                    active0;
    logic                    hsync0;
    logic                    vsync0;
    logic [HW-CELL_LOG2-1:0] col;
    logic [VW-CELL_LOG2-1:0] row;
    logic [ADDR_W-1:0]       addr_next;
    logic                    in_grid;
    logic                    ant_latch;
    logic [5:0]              ant_x_q;
    logic [5:0]              ant_y_q;
    pix_flags_t              s0;
    pix_flags_t              s1;
    logic [2:0]              code_next;

    lcd_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active0),
        .hsync  (hsync0),
        .vsync  (vsync0)
    );

    assign col       = h_cnt[HW-1:CELL_LOG2];
    assign row       = v_cnt[VW-1:CELL_LOG2];
    assign addr_next = ADDR_W'(32'(row) * GRID_W + 32'(col));
    assign in_grid   = (32'(row) < GRID_H) && (32'(col) < GRID_W);
    assign ant_latch = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));

    always_comb begin
        s0             = FLAGS_IDLE;
        s0.active      = active0;
        s0.grid        = (h_cnt[CELL_LOG2-1:0] == '0) || (v_cnt[CELL_LOG2-1:0] == '0);
        s0.ant         = (32'(col) == 32'(ant_x_q)) && (32'(row) == 32'(ant_y_q));
        s0.hsync       = hsync0;
        s0.vsync       = vsync0;
        s0.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Ant position only moves at the start of vertical blank so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ant_x_q <= '0;
            ant_y_q <= '0;
        end else if (ant_latch) begin
            ant_x_q <= ant_x;
            ant_y_q <= ant_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1           <= FLAGS_IDLE;
            cell_rd_addr <= '0;
        end else begin
            s1 <= s0;
            if (active0 && in_grid) begin
                cell_rd_addr <= addr_next;
            end
        end
    end

    always_comb begin
        code_next = CODE_CELL;
        if (!s1.active) begin
            code_next = CODE_BLACK;
        end else if (s1.grid) begin
            code_next = CODE_GRID;
        end else if (s1.ant) begin
            code_next = CODE_ANT;
        end else if (cell_rd_data) begin
            code_next = CODE_BLACK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icolor8     <= CODE_BLACK;
            enable      <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            icolor8     <= code_next;
            enable      <= s1.active;
            hsync       <= s1.hsync;
            vsync       <= s1.vsync;
            frame_start <= s1.frame_start;
        end
    end

endmodule
